// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default source-tag base and a small index helper.
// Optional feature macro: UART_ARB_TAG_EN (adds the TAG state).
package uart_pkg;

  // Default base value of the source tag byte (tag = base + requester index)
  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hF0;

  // Arbiter FSM states; TAG only exists when tagging is compiled in
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
`ifdef UART_ARB_TAG_EN
    TAG       = 3'd2,
`endif
    SEND      = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

  // (idx + off) modulo n, for idx < n and off <= n, n <= 8
  function automatic logic [2:0] wrap_add(input logic [2:0] idx,
                                          input logic [3:0] off,
                                          input logic [3:0] n);
    logic [3:0] sum;
    sum = {1'b0, idx} + off;
    if (sum >= n) sum = sum - n;
    return sum[2:0];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: combinational priority rotation starting at a
// registered pointer; the pointer moves to the slot after the winner
// whenever the owner signals an arbitration.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [2:0]         pick,
  output logic               found
);

  localparam logic [3:0] N = 4'(NUM_REQ);

  logic [2:0] ptr_reg;
  logic [2:0] cand [NUM_REQ];
  logic [7:0] req_ext;
  logic [NUM_REQ-1:0] hit;

  // Zero-extend the request vector so any 3-bit index is in range
  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
  end

  // Candidate k is the k-th requester after the pointer, wrapping around
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = wrap_add(ptr_reg, 4'(gi), N);
      assign hit[gi]  = req_ext[cand[gi]];
    end
  endgenerate

  // First requesting candidate in rotated order wins
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && hit[k]) begin
        found = 1'b1;
        pick  = cand[k];
      end
    end
  end

  // Pointer advances past the winner on each arbitration that grants
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= 3'd0;
    end else if (update && found) begin
      ptr_reg <= wrap_add(pick, 4'd1, N);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART transmit arbiter: grants one requester at a time (round-robin),
// holds the grant for a whole packet and feeds its bytes to a UART
// transmitter using a strobe / tx_ready busy-then-idle handshake.
// Optional feature macro: UART_ARB_TAG_EN (prefix each packet with a
// source tag byte TAG_BASE + grant index).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter logic [7:0] TAG_BASE = TAG_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  state_t             state_reg;
  logic               tx_valid_reg;
  logic [7:0]         tx_data_reg;
  logic [NUM_REQ-1:0] ready_reg;
  logic [2:0]         grant_reg;
  logic               last_reg;
  logic               busy_reg;

  logic [7:0]         valid_ext;
  logic [7:0]         last_ext;
  logic [7:0]         byte_arr [8];
  logic [NUM_REQ-1:0] grant_onehot;
  logic [2:0]         pick_idx;
  logic               pick_found;
  logic               arb_update;

  // Spread the per-requester inputs over 8 slots so a 3-bit grant can index them
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_real
        assign valid_ext[gi] = req_valid[gi];
        assign last_ext[gi]  = req_last[gi];
        assign byte_arr[gi]  = req_data[8*gi +: 8];
      end else begin : g_pad
        assign valid_ext[gi] = 1'b0;
        assign last_ext[gi]  = 1'b0;
        assign byte_arr[gi]  = 8'h00;
      end
    end
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign grant_onehot[gi] = (grant_reg == 3'(gi));
    end
  endgenerate

  assign arb_update = (state_reg == ARB);

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .update (arb_update),
    .pick   (pick_idx),
    .found  (pick_found)
  );

  // Packet FSM with registered strobes; strobes default low so each is one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      ready_reg    <= '0;
      grant_reg    <= 3'd0;
      last_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      tx_valid_reg <= 1'b0;
      ready_reg    <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_valid) begin
            state_reg <= ARB;
            busy_reg  <= 1'b1;
          end
        end
        ARB: begin
          // A requester may have withdrawn since IDLE; then nothing is granted
          if (pick_found) begin
            grant_reg <= pick_idx;
`ifdef UART_ARB_TAG_EN
            state_reg <= TAG;
`else
            state_reg <= SEND;
`endif
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG: begin
          if (tx_ready) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= TAG_BASE + {5'b00000, grant_reg};
            last_reg     <= 1'b0;
            state_reg    <= WAIT_BUSY;
          end
        end
`endif
        SEND: begin
          // Grant is held indefinitely while the owner has no byte ready
          if (tx_ready && valid_ext[grant_reg]) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= byte_arr[grant_reg];
            ready_reg    <= grant_onehot;
            last_reg     <= last_ext[grant_reg];
            state_reg    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!tx_ready) state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            if (last_reg) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= SEND;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = ready_reg;
  assign tx_data_valid = tx_valid_reg;
  assign tx_data       = tx_data_reg;
  assign grant_id      = grant_reg;
  assign busy          = busy_reg;

endmodule
